instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Field-to-word RV64I instruction encoder, the inverse of the decode stage: it takes op class, funct3,
//  funct7b5, rd/rs1/rs2 and a signed immediate, and builds the 32-bit instruction word.
//  Encoded words are written sequentially into instruction memory through a valid/ready write port.
//  Used by the self-test / boot program builder. Out-of-range requests are dropped and counted, never emitted.
// PARAMETERS
//  ADDR_W   10   instruction memory word-address width
//  DEPTH    1024 number of instruction words; address wraps DEPTH-1 -> 0
//  ERR_W    8    width of the error counter (saturating)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  cfg_load    in   1      load write pointer from cfg_base; drops any pending output word
//  cfg_base    in   ADDR_W start word address
//  req_valid   in   1      request present
//  req_ready   out  1      request accepted when req_valid && req_ready
//  req_class   in   4      0 LOAD,1 STORE,2 R,3 I,4 BRANCH,5 LUI,6 AUIPC,7 JAL,8 JALR,9 I64,10 R64; 11-15 illegal
//  req_funct3  in   3      funct3 field
//  req_f7b5    in   1      bit 30 (sub/sra/sraw/srai)
//  req_rd      in   5      destination register
//  req_rs1     in   5      source register 1
//  req_rs2     in   5      source register 2
//  req_imm     in   32     signed byte offset / immediate; U-type: full value, imm[11:0] must be 0
//  imem_we     out  1      write valid
//  imem_ready  in   1      memory accepts write this cycle
//  imem_addr   out  ADDR_W word address of the current write
//  imem_wdata  out  32     encoded instruction
//  wr_count    out  ADDR_W+1 words written since reset/cfg_load (saturates at DEPTH)
//  err         out  1      sticky: some request was illegal
//  err_count   out  ERR_W  number of dropped requests (saturating)
// BEHAVIOUR
//  - Reset: imem_we=0, imem_addr=0, imem_wdata=0, wr_count=0, err=0, err_count=0; req_ready=1 after reset.
//  - One output register: req_ready = !imem_we || imem_ready (full throughput, no bubble).
//  - Accepted legal request -> imem_we=1 with imem_wdata on the next cycle (1-cycle latency).
//  - imem_we/addr/wdata hold stable until imem_ready; on imem_we&&imem_ready, addr+1 (wrap) and wr_count+1.
//  - Opcodes: 0000011,0100011,0110011,0010011,1100011,0110111,0010111,1101111,1100111,0011011,0111011.
//  - R/R64: {funct7=f7b5<<5,rs2,rs1,f3,rd,op}. I/LOAD/JALR: imm[11:0] in [31:20]. S: imm[11:5],imm[4:0].
//    B: imm[12|10:5],imm[4:1|11]. J: imm[20|10:1|11|19:12]. U: imm[31:12]. JALR forces funct3=000.
//  - Shifts (I f3=001/101: shamt=imm[5:0]; I64: imm[4:0]); f7b5 goes to bit 30; other imm bits must be 0.
//  - Legality: I/S/JALR imm in [-2048,2047]; B in [-4096,4094], even; J in [-1048576,1048574], even;
//    U imm[11:0]==0; class 11-15 illegal; LOAD f3=111, STORE f3>=100, BRANCH f3=010/011, I64 f3 not in {000,001,101},
//    R64 f3 not in {000,001,101} illegal. Illegal request: accepted (req_ready unaffected), not emitted,
//    err<=1, err_count+1 (saturating), output register and address untouched.
//  - cfg_load: highest priority; imem_we<=0, imem_addr<=cfg_base, wr_count<=0; a request offered in the
//    same cycle is not accepted (req_ready=0 while cfg_load=1). err/err_count are not cleared.
//  - Wrap: address DEPTH-1 write -> next address 0; wr_count saturates at DEPTH.
//  - Reset mid-transfer: pending word lost, all state to reset values immediately.
// TESTING
//  - addi x1,x0,5 (class 3,f3 0,rd 1,imm 5) -> one cycle later imem_we=1, wdata=0x00500093, addr=0.
//  - lui x2,0x12345 (imm 0x12345000) -> 0x12345137; beq x1,x2,+8 -> 0x00208463; sw x2,4(x1) -> 0x0020A223.
//  - addi imm=2048, and beq imm=7 -> no write, err=1, err_count=2, addr unchanged.
//  - imem_ready=0 for 3 cycles with back-to-back requests -> wdata held stable, req_ready=0, no loss/dup.
//  - cfg_base=DEPTH-1, two legal requests -> writes at DEPTH-1 then 0; wr_count=2.
//  - cfg_load while imem_we=1 and stalled -> word dropped, next write at cfg_base; reset mid-stall -> imem_we=0.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose
//   Builds 32-bit RV64I instruction words from decoded fields. This is the
//   inverse of the decode stage. Each accepted, legal request is encoded into a
//   single output register and written to instruction memory through a
//   valid/ready write port, at consecutive word addresses. Illegal requests are
//   consumed, never written, and counted.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   cfg_load, cfg_base  reload the write pointer (drops any pending word)
//   req_valid/req_ready request handshake
//   req_class           op class (0 LOAD .. 10 R64; 11-15 illegal)
//   req_funct3/req_f7b5 funct3 field and instruction bit 30
//   req_rd/rs1/rs2      register fields
//   req_imm             signed immediate (U-type: full value, low 12 bits 0)
//   imem_we/imem_ready  memory write handshake
//   imem_addr/wdata     word address and encoded instruction
//   wr_count            words written since reset/cfg_load (saturates at DEPTH)
//   err, err_count      sticky illegal flag and dropped-request count (saturating)
// -----------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_load,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_class,
   input  logic [2:0]        req_funct3,
   input  logic              req_f7b5,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [31:0]       req_imm,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   wr_count,
   output logic              err,
   output logic [ERR_W-1:0]  err_count
);

   // Op classes as presented on req_class; 11-15 have no encoding.
   typedef enum logic [3:0] {
      cls_load   = 4'd0,
      cls_store  = 4'd1,
      cls_r      = 4'd2,
      cls_i      = 4'd3,
      cls_branch = 4'd4,
      cls_lui    = 4'd5,
      cls_auipc  = 4'd6,
      cls_jal    = 4'd7,
      cls_jalr   = 4'd8,
      cls_i64    = 4'd9,
      cls_r64    = 4'd10
   } op_class_t;

   localparam logic [6:0] opc_load   = 7'b0000011;
   localparam logic [6:0] opc_store  = 7'b0100011;
   localparam logic [6:0] opc_op     = 7'b0110011;
   localparam logic [6:0] opc_op_imm = 7'b0010011;
   localparam logic [6:0] opc_branch = 7'b1100011;
   localparam logic [6:0] opc_lui    = 7'b0110111;
   localparam logic [6:0] opc_auipc  = 7'b0010111;
   localparam logic [6:0] opc_jal    = 7'b1101111;
   localparam logic [6:0] opc_jalr   = 7'b1100111;
   localparam logic [6:0] opc_op_i32 = 7'b0011011;
   localparam logic [6:0] opc_op_32  = 7'b0111011;

   localparam logic [ADDR_W-1:0] addr_last = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   count_max = (ADDR_W + 1)'(DEPTH);
   localparam logic [ERR_W-1:0]  err_max   = {ERR_W{1'b1}};

   // --------------------------------------------------------------------------
   // Immediate range qualifiers
   // --------------------------------------------------------------------------
   logic signed [31:0] simm;
   logic               fits_i;      // 12-bit signed (I, S, LOAD, JALR)
   logic               fits_b;      // 13-bit signed, even (branch)
   logic               fits_j;      // 21-bit signed, even (JAL)
   logic               fits_u;      // low 12 bits clear (LUI/AUIPC)
   logic               shamt6_ok;   // RV64 shift amount 0..63
   logic               shamt5_ok;   // word shift amount 0..31
   logic               is_shift;    // funct3 selects SLLI/SRLI/SRAI family

   assign simm      = $signed(req_imm);
   assign fits_i    = (simm >= -32'sd2048) && (simm <= 32'sd2047);
   assign fits_b    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !req_imm[0];
   assign fits_j    = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !req_imm[0];
   assign fits_u    = (req_imm[11:0] == 12'h000);
   assign shamt6_ok = (req_imm[31:6] == '0);
   assign shamt5_ok = (req_imm[31:5] == '0);
   assign is_shift  = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

   // --------------------------------------------------------------------------
   // Field-to-word encoding and legality
   // --------------------------------------------------------------------------
   logic [31:0] enc_word;
   logic        enc_legal;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      enc_word  = '0;
      enc_legal = 1'b0;

      case (req_class)
         cls_load: begin
            enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, opc_load};
            enc_legal = fits_i && (req_funct3 != 3'b111);
         end

         cls_store: begin
            enc_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:0], opc_store};
            enc_legal = fits_i && !req_funct3[2];
         end

         cls_r: begin
            enc_word  = {1'b0, req_f7b5, 5'b00000, req_rs2, req_rs1, req_funct3,
                         req_rd, opc_op};
            enc_legal = 1'b1;
         end

         cls_i: begin
            if (is_shift) begin
               // Shift-immediate: 6-bit shamt, bit 30 selects arithmetic.
               enc_word  = {1'b0, req_f7b5, 4'b0000, req_imm[5:0], req_rs1,
                            req_funct3, req_rd, opc_op_imm};
               enc_legal = shamt6_ok;
            end else begin
               enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, opc_op_imm};
               enc_legal = fits_i;
            end
         end

         cls_branch: begin
            // Offset bit 0 is implicit; bits are scattered to keep the sign at 31.
            enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                         req_imm[4:1], req_imm[11], opc_branch};
            enc_legal = fits_b && (req_funct3 != 3'b010) && (req_funct3 != 3'b011);
         end

         cls_lui: begin
            enc_word  = {req_imm[31:12], req_rd, opc_lui};
            enc_legal = fits_u;
         end

         cls_auipc: begin
            enc_word  = {req_imm[31:12], req_rd, opc_auipc};
            enc_legal = fits_u;
         end

         cls_jal: begin
            enc_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                         req_rd, opc_jal};
            enc_legal = fits_j;
         end

         cls_jalr: begin
            // JALR has only one funct3 encoding; the request field is ignored.
            enc_word  = {req_imm[11:0], req_rs1, 3'b000, req_rd, opc_jalr};
            enc_legal = fits_i;
         end

         cls_i64: begin
            case (req_funct3)
               3'b000: begin
                  enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, opc_op_i32};
                  enc_legal = fits_i;
               end
               3'b001, 3'b101: begin
                  // Word shifts: 5-bit shamt, bit 25 stays zero.
                  enc_word  = {1'b0, req_f7b5, 5'b00000, req_imm[4:0], req_rs1,
                               req_funct3, req_rd, opc_op_i32};
                  enc_legal = shamt5_ok;
               end
               default: enc_legal = 1'b0;
            endcase
         end

         cls_r64: begin
            enc_word  = {1'b0, req_f7b5, 5'b00000, req_rs2, req_rs1, req_funct3,
                         req_rd, opc_op_32};
            enc_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b101);
         end

         default: enc_legal = 1'b0;
      endcase
   end

   // --------------------------------------------------------------------------
   // Handshakes
   // --------------------------------------------------------------------------
   logic accept;       // request consumed this cycle (legal or not)
   logic fire;         // memory takes the pending word this cycle
   logic [ADDR_W-1:0] addr_next;

   // The single output slot can be refilled in the same cycle it drains.
   assign req_ready = !cfg_load && (!imem_we || imem_ready);
   assign accept    = req_valid && req_ready;
   assign fire      = imem_we && imem_ready;
   assign addr_next = (imem_addr == addr_last) ? '0 : imem_addr + 1'b1;

   // --------------------------------------------------------------------------
   // Output register, write pointer and counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         wr_count   <= '0;
         err        <= 1'b0;
         err_count  <= '0;
      end else if (cfg_load) begin
         // Any pending word is abandoned; error history is kept.
         imem_we   <= 1'b0;
         imem_addr <= cfg_base;
         wr_count  <= '0;
      end else begin
         if (fire) begin
            imem_addr <= addr_next;
            if (wr_count != count_max) wr_count <= wr_count + 1'b1;
         end

         if (accept && enc_legal) begin
            imem_we    <= 1'b1;
            imem_wdata <= enc_word;
         end else if (fire) begin
            imem_we <= 1'b0;
         end

         if (accept && !enc_legal) begin
            err <= 1'b1;
            if (err_count != err_max) err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
